alarm_controller: RTL and testbench
===================================

Name: alarm_controller

Overview:
- Sequencing controller for the keypad security system.
- Consumes decoded key events from the keypad column/row scanner and the door `is_breach` sensor.
- Runs the arm/disarm state machine, the entry-delay timer, the wrong-code lockout and the alert outputs.
- Replaces the fixed-code check buried in the scanner: the scanner only decodes keys; this block decides policy.

Parameters:
- CODE_LEN, 4, passcode length in digits (1..8).
- PASSCODE, 32'h0000_1865, BCD passcode; the low CODE_LEN nibbles are used, MS digit entered first.
- ENTRY_DELAY, 100, cycles from breach detection to alarm while armed (>=1).
- MAX_ATTEMPTS, 3, consecutive wrong codes that trigger lockout (>=1).
- LOCKOUT_CYCLES, 1000, cycles for which keys are ignored after lockout (>=1).
- BLINK_LOG2, 4, led blinks at half-period 2^(BLINK_LOG2-1) cycles.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-low
- key_valid  input  1  one-cycle pulse: key_code is valid this cycle
- key_code  input  4  0-9 = digit, 4'hA = clear entry, others ignored
- is_breach  input  1  level; door/window open
- is_enabled  output  1  system armed (state != DISARMED)
- led  output  1  status indicator
- alert_authorities  output  1  sticky alarm/alert flag
- locked_out  output  1  keypad lockout active
- digit_count  output  4  digits currently buffered (0..CODE_LEN-1)

Behaviour:
- Reset (rst==0 at clk edge): state=DISARMED; buffer, digit_count, attempt count, timers all 0; is_enabled, led, alert_authorities, locked_out all 0.
- Key handling, ignored entirely while locked_out=1:
  - Digit: shifts into the buffer and increments digit_count.
  - 4'hA: clears the buffer and digit_count.
- Code evaluation:
  - On the edge accepting the CODE_LEN-th digit, the code (buffer + incoming digit) is compared to PASSCODE.
  - Same edge: buffer and digit_count clear, and code_ok or code_bad takes effect. Outputs reflect the result the following cycle.
- code_ok: attempt count := 0.
- code_bad: attempt count +1. On reaching MAX_ATTEMPTS: locked_out := 1, lockout timer := LOCKOUT_CYCLES, attempt count := 0.
- Lockout timer: decrements each cycle; locked_out drops on the edge where it reaches 0. State-machine timers keep running during lockout.
- States:
  - DISARMED: code_ok -> ARMED.
  - ARMED: code_ok -> DISARMED. Else is_breach=1 -> ENTRY, entry timer := ENTRY_DELAY-1.
  - ENTRY: code_ok -> DISARMED. Else timer==0 -> ALARM. Else timer -1. is_breach is ignored in ENTRY.
  - ALARM: alert_authorities := 1. code_ok -> DISARMED.
- alert_authorities stays set after disarm. It clears only on reset or on a code_ok entered from DISARMED.
- Precedence: code_ok beats breach (ARMED) and beats timer expiry (ENTRY) in the same cycle.
- led:
  - DISARMED: 0.
  - ARMED: 1.
  - ENTRY/ALARM: MSB of a free-running BLINK_LOG2-bit counter that resets to 0 on entry to ENTRY.
- Mid-entry reset: all state is lost and the block returns to DISARMED with no alert.

Optional Feature:
- Macro: DURESS_CODE_EN.
- Defined:
  - Adds parameter DURESS_CODE (default 32'h0000_1866).
  - A matching entry acts as code_ok for the state machine (disarms or arms as normal) and also sets alert_authorities=1 on the same edge.
  - led and is_enabled behave exactly as for the real code, so the disarm is silent to the intruder.
- Undefined: DURESS_CODE does not exist; that entry is treated as code_bad.

Test Plan:
- Bench parameters: ENTRY_DELAY=8, LOCKOUT_CYCLES=16, MAX_ATTEMPTS=3.
- Keys 1,8,6,5 from reset -> is_enabled=1 and led=1 one cycle after the 4th key; alert_authorities=0; digit_count back to 0.
- Armed, is_breach=1 for 1 cycle, no keys -> ENTRY with led blinking; exactly 8 cycles later state=ALARM and alert_authorities=1; then 1,8,6,5 -> is_enabled=0 with alert_authorities still 1.
- Armed, is_breach=1, then 1,8,6,5 completed at cycle 5 -> DISARMED, alert_authorities never asserted. Also cover the 4th digit landing on the same edge as timer expiry -> DISARMED.
- Three wrong codes 1,2,3,4 -> locked_out=1; a following 1,8,6,5 is ignored (is_enabled stays 0); 16 cycles later locked_out=0, and 1,8,6,5 then arms.
- Keys 1,8, then 4'hA, then 6,5 -> digit_count=2 and no state change. Also cover key_code=4'hC, which is ignored and leaves digit_count unchanged.
- rst=0 for 1 cycle while in ENTRY -> all outputs 0 the next cycle; with DURESS_CODE_EN, 1,8,6,6 while armed -> is_enabled=0 and alert_authorities=1.

Source files
------------

// File: rtl/alarm_controller.sv
// alarm_controller -- policy block of the keypad security system.
// Takes decoded key events and the door breach level and runs the
// arm/disarm state machine, entry delay, wrong-code lockout and alerts.
// Optional feature: define DURESS_CODE_EN to add a DURESS_CODE parameter.
// That code disarms or arms like the real code and silently raises
// alert_authorities.
module alarm_controller #(
    parameter int          CODE_LEN       = 4,
    parameter logic [31:0] PASSCODE       = 32'h0000_1865,
`ifdef DURESS_CODE_EN
    parameter logic [31:0] DURESS_CODE    = 32'h0000_1866,
`endif
    parameter int          ENTRY_DELAY    = 100,
    parameter int          MAX_ATTEMPTS   = 3,
    parameter int          LOCKOUT_CYCLES = 1000,
    parameter int          BLINK_LOG2     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       is_breach,
    output logic       is_enabled,
    output logic       led,
    output logic       alert_authorities,
    output logic       locked_out,
    output logic [3:0] digit_count
);

    localparam int CODE_W = 4 * CODE_LEN;
    localparam int ET_W   = (ENTRY_DELAY > 1) ? $clog2(ENTRY_DELAY) : 1;
    localparam int LT_W   = $clog2(LOCKOUT_CYCLES + 1);
    localparam int AT_W   = $clog2(MAX_ATTEMPTS + 1);

    typedef enum logic [1:0] {
        DISARMED,
        ARMED,
        ENTRY,
        ALARM
    } state_t;

    state_t                  state_q, state_d;
    logic [CODE_W-1:0]       buf_q, buf_d;
    logic [3:0]              digit_cnt_q, digit_cnt_d;
    logic [AT_W-1:0]         attempt_q, attempt_d;
    logic [LT_W-1:0]         lock_tmr_q, lock_tmr_d;
    logic                    locked_q, locked_d;
    logic [ET_W-1:0]         entry_tmr_q, entry_tmr_d;
    logic [BLINK_LOG2-1:0]   blink_q, blink_d;
    logic                    alert_q, alert_d;

    logic [CODE_W-1:0]       code_word;
    logic                    code_ok;
    logic                    code_bad;
`ifdef DURESS_CODE_EN
    logic                    duress_hit;
`endif

    // Key buffering and code evaluation on the CODE_LEN-th accepted digit.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        buf_d       = buf_q;
        digit_cnt_d = digit_cnt_q;
        code_ok     = 1'b0;
        code_bad    = 1'b0;
`ifdef DURESS_CODE_EN
        duress_hit  = 1'b0;
`endif
        code_word   = (buf_q << 4) | CODE_W'(key_code);
        if (key_valid && !locked_q) begin
            if (key_code <= 4'd9) begin
                if (digit_cnt_q == 4'(CODE_LEN - 1)) begin
                    buf_d       = '0;
                    digit_cnt_d = '0;
                    if (code_word == PASSCODE[CODE_W-1:0]) begin
                        code_ok = 1'b1;
`ifdef DURESS_CODE_EN
                    end else if (code_word == DURESS_CODE[CODE_W-1:0]) begin
                        code_ok    = 1'b1;
                        duress_hit = 1'b1;
`endif
                    end else begin
                        code_bad = 1'b1;
                    end
                end else begin
                    buf_d       = code_word;
                    digit_cnt_d = digit_cnt_q + 4'd1;
                end
            end else if (key_code == 4'hA) begin
                buf_d       = '0;
                digit_cnt_d = '0;
            end
        end
    end

    // Consecutive wrong-code counting and the keypad lockout timer.
    always_comb begin
        attempt_d  = attempt_q;
        locked_d   = locked_q;
        lock_tmr_d = lock_tmr_q;
        if (locked_q) begin
            lock_tmr_d = lock_tmr_q - LT_W'(1);
            if (lock_tmr_q == LT_W'(1)) begin
                locked_d = 1'b0;
            end
        end
        if (code_ok) begin
            attempt_d = '0;
        end else if (code_bad) begin
            if (attempt_q + AT_W'(1) == AT_W'(MAX_ATTEMPTS)) begin
                attempt_d  = '0;
                locked_d   = 1'b1;
                lock_tmr_d = LT_W'(LOCKOUT_CYCLES);
            end else begin
                attempt_d = attempt_q + AT_W'(1);
            end
        end
    end

    // Arm/disarm state machine; a valid code always wins over breach or expiry.
    always_comb begin
        state_d     = state_q;
        entry_tmr_d = entry_tmr_q;
        blink_d     = blink_q + BLINK_LOG2'(1);
        alert_d     = alert_q;
        case (state_q)
            DISARMED: begin
                if (code_ok) begin
                    state_d = ARMED;
                    alert_d = 1'b0;
                end
            end
            ARMED: begin
                if (code_ok) begin
                    state_d = DISARMED;
                end else if (is_breach) begin
                    state_d     = ENTRY;
                    entry_tmr_d = ET_W'(ENTRY_DELAY - 1);
                    blink_d     = '0;
                end
            end
            ENTRY: begin
                if (code_ok) begin
                    state_d = DISARMED;
                end else if (entry_tmr_q == '0) begin
                    state_d = ALARM;
                    alert_d = 1'b1;
                end else begin
                    entry_tmr_d = entry_tmr_q - ET_W'(1);
                end
            end
            ALARM: begin
                alert_d = 1'b1;
                if (code_ok) begin
                    state_d = DISARMED;
                end
            end
            default: state_d = DISARMED;
        endcase
`ifdef DURESS_CODE_EN
        if (duress_hit) begin
            alert_d = 1'b1;
        end
`endif
    end

    // State registers with synchronous active-low reset.
    // NOTE: flops use non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= DISARMED;
            buf_q       <= '0;
            digit_cnt_q <= '0;
            attempt_q   <= '0;
            lock_tmr_q  <= '0;
            locked_q    <= 1'b0;
            entry_tmr_q <= '0;
            blink_q     <= '0;
            alert_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            digit_cnt_q <= digit_cnt_d;
            attempt_q   <= attempt_d;
            lock_tmr_q  <= lock_tmr_d;
            locked_q    <= locked_d;
            entry_tmr_q <= entry_tmr_d;
            blink_q     <= blink_d;
            alert_q     <= alert_d;
        end
    end

    assign is_enabled        = (state_q != DISARMED);
    assign led               = (state_q == ARMED) ||
                               (((state_q == ENTRY) || (state_q == ALARM)) && blink_q[BLINK_LOG2-1]);
    assign alert_authorities = alert_q;
    assign locked_out        = locked_q;
    assign digit_count       = digit_cnt_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Testbench for alarm_controller: a table of single-cycle vectors, directed
// multi-cycle sequences, then random stimulus against a behavioural model.
module tb_alarm_controller;

    localparam int     CODE_LEN       = 4;
    localparam longint PASSCODE       = 64'h1865;
    localparam int     ENTRY_DELAY    = 8;
    localparam int     MAX_ATTEMPTS   = 3;
    localparam int     LOCKOUT_CYCLES = 16;
    localparam int     BLINK_LOG2     = 4;
`ifdef DURESS_CODE_EN
    localparam longint DURESS         = 64'h1866;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic       is_breach;
    logic       is_enabled;
    logic       led;
    logic       alert_authorities;
    logic       locked_out;
    logic [3:0] digit_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alarm_controller #(
        .CODE_LEN      (CODE_LEN),
        .PASSCODE      (32'h0000_1865),
        .ENTRY_DELAY   (ENTRY_DELAY),
        .MAX_ATTEMPTS  (MAX_ATTEMPTS),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
        .BLINK_LOG2    (BLINK_LOG2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .key_valid        (key_valid),
        .key_code         (key_code),
        .is_breach        (is_breach),
        .is_enabled       (is_enabled),
        .led              (led),
        .alert_authorities(alert_authorities),
        .locked_out       (locked_out),
        .digit_count      (digit_count)
    );

    // ---------------- behavioural reference model ----------------
    typedef enum int {M_OFF, M_ON, M_COUNTDOWN, M_SIREN} mmode_t;

    mmode_t m_mode = M_OFF;
    int     m_digits[$];
    int     m_wrong = 0;
    int     m_lock_left = 0;
    longint m_cycle = 0;
    longint m_entry_start = 0;
    longint m_blink_origin = 0;
    bit     m_alert = 1'b0;

    function automatic void model_step(logic r, logic kv, logic [3:0] kc, logic br);
        bit     ok;
        bit     bad;
        bit     duress;
        bit     locked_now;
        longint val;
        m_cycle++;
        if (!r) begin
            m_mode = M_OFF;
            m_digits.delete();
            m_wrong = 0;
            m_lock_left = 0;
            m_alert = 1'b0;
            m_blink_origin = m_cycle;
            m_entry_start = m_cycle;
            return;
        end
        ok = 1'b0;
        bad = 1'b0;
        duress = 1'b0;
        locked_now = (m_lock_left > 0);
        if (locked_now) m_lock_left--;
        if (kv && !locked_now) begin
            if (kc <= 4'd9) begin
                m_digits.push_back(int'(kc));
                if (m_digits.size() == CODE_LEN) begin
                    val = 0;
                    foreach (m_digits[i]) val = val * 16 + m_digits[i];
                    if (val == (PASSCODE & ((64'd1 << (4 * CODE_LEN)) - 1))) ok = 1'b1;
`ifdef DURESS_CODE_EN
                    else if (val == (DURESS & ((64'd1 << (4 * CODE_LEN)) - 1))) begin
                        ok = 1'b1;
                        duress = 1'b1;
                    end
`endif
                    else bad = 1'b1;
                    m_digits.delete();
                end
            end else if (kc == 4'hA) begin
                m_digits.delete();
            end
        end
        if (ok) m_wrong = 0;
        else if (bad) begin
            m_wrong++;
            if (m_wrong == MAX_ATTEMPTS) begin
                m_wrong = 0;
                m_lock_left = LOCKOUT_CYCLES;
            end
        end
        case (m_mode)
            M_OFF: if (ok) begin
                m_mode = M_ON;
                m_alert = 1'b0;
            end
            M_ON: if (ok) m_mode = M_OFF;
                  else if (br) begin
                      m_mode = M_COUNTDOWN;
                      m_entry_start = m_cycle;
                      m_blink_origin = m_cycle;
                  end
            M_COUNTDOWN: if (ok) m_mode = M_OFF;
                  else if (m_cycle - m_entry_start == ENTRY_DELAY) begin
                      m_mode = M_SIREN;
                      m_alert = 1'b1;
                  end
            default: if (ok) m_mode = M_OFF;
        endcase
        if (duress) m_alert = 1'b1;
    endfunction

    function automatic logic exp_led();
        longint age;
        age = m_cycle - m_blink_origin;
        if (m_mode == M_OFF) return 1'b0;
        if (m_mode == M_ON) return 1'b1;
        return ((age / (64'd1 << (BLINK_LOG2 - 1))) % 2) == 1;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive inputs, take one clock edge, advance the model, sample 1 unit later.
    task automatic step(input logic r, input logic kv, input logic [3:0] kc, input logic br);
        rst = r;
        key_valid = kv;
        key_code = kc;
        is_breach = br;
        @(posedge clk);
        model_step(r, kv, kc, br);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic enter_code(input logic [15:0] c);
        for (int i = 3; i >= 0; i--) step(1'b1, 1'b1, c[i*4 +: 4], 1'b0);
    endtask

    task automatic check_all(input string tag, input logic en, input logic ld,
                             input logic al, input logic lk, input logic [3:0] dc);
        check({tag, "_en"},    is_enabled,        en);
        check({tag, "_led"},   led,               ld);
        check({tag, "_alert"}, alert_authorities, al);
        check({tag, "_lock"},  locked_out,        lk);
        check({tag, "_dc"},    digit_count,       dc);
    endtask

    typedef struct {
        logic       r;
        logic       kv;
        logic [3:0] kc;
        logic       br;
        logic       en;
        logic       ld;
        logic       al;
        logic       lk;
        logic [3:0] dc;
    } vec_t;

    vec_t tbl[24];
    int   q_keys[$];

    initial begin
        //          rst   kv    key    brch  en    led   alrt  lock  dc
        tbl[0]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[1]  = '{1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
        tbl[2]  = '{1'b1, 1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2};
        tbl[3]  = '{1'b1, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[4]  = '{1'b1, 1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
        tbl[5]  = '{1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2};
        tbl[6]  = '{1'b1, 1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2};
        tbl[7]  = '{1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2};
        tbl[8]  = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2};
        tbl[9]  = '{1'b1, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[10] = '{1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
        tbl[11] = '{1'b1, 1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2};
        tbl[12] = '{1'b1, 1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3};
        tbl[13] = '{1'b1, 1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
        tbl[14] = '{1'b1, 1'b1, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
        tbl[15] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
        tbl[16] = '{1'b1, 1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1};
        tbl[17] = '{1'b1, 1'b1, 4'h2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2};
        tbl[18] = '{1'b1, 1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3};
        tbl[19] = '{1'b1, 1'b1, 4'h4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
        tbl[20] = '{1'b1, 1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1};
        tbl[21] = '{1'b1, 1'b1, 4'h8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2};
        tbl[22] = '{1'b1, 1'b1, 4'h6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3};
        tbl[23] = '{1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};

        // ---- table-driven single-cycle vectors ----
        for (int i = 0; i < 24; i++) begin
            step(tbl[i].r, tbl[i].kv, tbl[i].kc, tbl[i].br);
            check_all($sformatf("vec%0d", i), tbl[i].en, tbl[i].ld, tbl[i].al, tbl[i].lk, tbl[i].dc);
        end

        // ---- breach with no code: ENTRY for 8 cycles, then ALARM ----
        step(1'b0, 1'b0, 4'h0, 1'b0);
        enter_code(16'h1865);
        check_all("arm", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 4'h0, 1'b1);
        check("entry_en", is_enabled, 1'b1);
        check("entry_led_reset", led, 1'b0);
        for (int k = 1; k < ENTRY_DELAY; k++) begin
            step(1'b1, 1'b0, 4'h0, 1'b0);
            check($sformatf("entry_noalert%0d", k), alert_authorities, 1'b0);
        end
        step(1'b1, 1'b0, 4'h0, 1'b0);
        check("alarm_alert", alert_authorities, 1'b1);
        check("alarm_en", is_enabled, 1'b1);
        check("alarm_led_on", led, 1'b1);
        idle(8);
        check("alarm_led_off", led, 1'b0);
        enter_code(16'h1865);
        check_all("alarm_disarm", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        enter_code(16'h1865);
        check_all("rearm_clears_alert", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);

        // ---- breach, code completed 5 cycles in ----
        step(1'b1, 1'b0, 4'h0, 1'b1);
        idle(1);
        enter_code(16'h1865);
        check_all("entry_disarm", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        // ---- 4th digit on the same edge as entry expiry ----
        enter_code(16'h1865);
        step(1'b1, 1'b0, 4'h0, 1'b1);
        idle(4);
        step(1'b1, 1'b1, 4'h1, 1'b0);
        step(1'b1, 1'b1, 4'h8, 1'b0);
        step(1'b1, 1'b1, 4'h6, 1'b0);
        check("expiry_pre_en", is_enabled, 1'b1);
        step(1'b1, 1'b1, 4'h5, 1'b0);
        check_all("expiry_race", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        // ---- lockout after three wrong codes ----
        step(1'b0, 1'b0, 4'h0, 1'b0);
        enter_code(16'h1234);
        check("wrong1_lock", locked_out, 1'b0);
        enter_code(16'h1234);
        enter_code(16'h1234);
        check("wrong3_lock", locked_out, 1'b1);
        enter_code(16'h1865);
        check_all("locked_ignore", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        idle(LOCKOUT_CYCLES - 5);
        check("lock_held", locked_out, 1'b1);
        idle(1);
        check("lock_release", locked_out, 1'b0);
        enter_code(16'h1865);
        check("post_lock_arm", is_enabled, 1'b1);

        // ---- reset during ENTRY ----
        step(1'b1, 1'b0, 4'h0, 1'b1);
        idle(2);
        step(1'b0, 1'b0, 4'h0, 1'b0);
        check_all("mid_entry_rst", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        idle(1);
        check_all("after_rst", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        // ---- duress code while armed ----
        enter_code(16'h1865);
        enter_code(16'h1866);
`ifdef DURESS_CODE_EN
        check_all("duress", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
`else
        check_all("near_miss_bad", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
`endif

        // ---- random stimulus against the behavioural model ----
        step(1'b0, 1'b0, 4'h0, 1'b0);
        for (int c = 0; c < 4000; c++) begin
            logic       r;
            logic       kv;
            logic       br;
            logic [3:0] kc;
            int         pick;
            if (q_keys.size() == 0) begin
                pick = int'($urandom_range(0, 9));
                if (pick < 4) begin
                    q_keys.push_back(1); q_keys.push_back(8);
                    q_keys.push_back(6); q_keys.push_back(5);
                end else if (pick == 4) begin
                    q_keys.push_back(1); q_keys.push_back(8);
                    q_keys.push_back(6); q_keys.push_back(6);
                end else if (pick < 7) begin
                    for (int j = 0; j < 4; j++) q_keys.push_back(int'($urandom_range(0, 9)));
                end else if (pick == 7) begin
                    q_keys.push_back(10);
                end else if (pick == 8) begin
                    q_keys.push_back(1); q_keys.push_back(8); q_keys.push_back(10);
                end else begin
                    q_keys.push_back(int'($urandom_range(11, 15)));
                end
            end
            kv = ($urandom_range(0, 2) != 0);
            if (kv) kc = 4'(q_keys.pop_front());
            else    kc = 4'($urandom_range(0, 15));
            br = ($urandom_range(0, 19) == 0);
            r  = ($urandom_range(0, 299) != 0);
            step(r, kv, kc, br);
            check($sformatf("rand%0d_en", c),    is_enabled,        m_mode != M_OFF);
            check($sformatf("rand%0d_led", c),   led,               exp_led());
            check($sformatf("rand%0d_alert", c), alert_authorities, m_alert);
            check($sformatf("rand%0d_lock", c),  locked_out,        m_lock_left > 0);
            check($sformatf("rand%0d_dc", c),    digit_count,       4'(m_digits.size()));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
